// File: rtl/multdiv_unit.sv
// Multiply/divide unit with HI/LO register pair for the execute stage.
// Captures operands on start, holds busy for a fixed latency, then commits to HI/LO.
module multdiv_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  start,
  input  logic [1:0]  multdivOP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic        HILOOP,
  output logic        busy,
  output logic [31:0] HILO_out
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [63:0] pend_q;
  logic        div0_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        is_uns;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;
  logic [63:0] mult_res;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign is_uns = multdivOP[0];

  // A 64x64 product truncated to 64 bits equals the exact signed/unsigned 32x32 product.
  always_comb begin
    a_ext    = is_uns ? {32'h0, A} : {{32{A[31]}}, A};
    b_ext    = is_uns ? {32'h0, B} : {{32{B[31]}}, B};
    product  = a_ext * b_ext;
    mult_res = multdivOP[1] ? ({hi_q, lo_q} + product) : product;
  end

  // Magnitude division; 0x80000000 / -1 falls out naturally as quotient 0x80000000.
  always_comb begin
    a_neg   = ~is_uns & A[31];
    b_neg   = ~is_uns & B[31];
    a_mag   = a_neg ? (~A + 32'd1) : A;
    b_mag   = b_neg ? (~B + 32'd1) : B;
    divisor = (B == 32'h0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem     = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= 64'h0;
      div0_q  <= 1'b0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start == 2'b01) begin
            pend_q  <= mult_res;
            div0_q  <= 1'b0;
            cnt_q   <= MULT_N;
            state_q <= RUN;
          end else if (start == 2'b10) begin
            pend_q  <= {rem, quot};
            div0_q  <= (B == 32'h0);
            cnt_q   <= DIV_N;
            state_q <= RUN;
          end else if (start == 2'b00) begin
            if (HIWrite) hi_q <= A;
            if (LOWrite) lo_q <= A;
          end
        end
        RUN: begin
          if (cnt_q == 4'd1) begin
            if (!div0_q) begin
              hi_q <= pend_q[63:32];
              lo_q <= pend_q[31:0];
            end
            cnt_q   <= 4'd0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q == RUN);
  assign HILO_out = HILOOP ? hi_q : lo_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: a cycle-level arithmetic model checked every cycle,
// plus literal expectations on HI/LO after each operation.
module tb_multdiv_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk;
  logic        reset;
  logic [1:0]  start;
  logic [1:0]  multdivOP;
  logic [31:0] A;
  logic [31:0] B;
  logic        HIWrite;
  logic        LOWrite;
  logic        HILOOP;
  logic        busy;
  logic [31:0] HILO_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  multdiv_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .multdivOP(multdivOP),
    .A(A), .B(B), .HIWrite(HIWrite), .LOWrite(LOWrite), .HILOOP(HILOOP),
    .busy(busy), .HILO_out(HILO_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_rem;
  logic [63:0] m_pend;
  logic        m_div0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  function automatic logic [63:0] model_mult(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    longint x;
    longint y;
    longint p;
    if (op[0]) begin
      x = longint'({32'h0, a});
      y = longint'({32'h0, b});
    end else begin
      x = $signed(a);
      y = $signed(b);
    end
    p = x * y;
    if (op[1]) p = p + longint'(acc);
    return 64'(p);
  endfunction

  function automatic logic [63:0] model_div(input logic uns, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa;
    int sb;
    int q;
    int r;
    if (b == 32'h0) return 64'h0;
    if (uns) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rem  <= 0;
      m_pend <= 64'h0;
      m_div0 <= 1'b0;
      m_hi   <= 32'h0;
      m_lo   <= 32'h0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1 && !m_div0) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (start == 2'b01) begin
      m_pend <= model_mult(multdivOP, A, B, {m_hi, m_lo});
      m_div0 <= 1'b0;
      m_rem  <= MULT_CYCLES;
    end else if (start == 2'b10) begin
      m_pend <= model_div(multdivOP[0], A, B);
      m_div0 <= (B == 32'h0);
      m_rem  <= DIV_CYCLES;
    end else if (start == 2'b00) begin
      if (HIWrite) m_hi <= A;
      if (LOWrite) m_lo <= A;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (busy !== (m_rem > 0)) begin
        n_fail++;
        $display("FAIL cyc_busy t=%0t: got %b expected %b", $time, busy, (m_rem > 0));
      end
      n_checks++;
      if (HILO_out !== (HILOOP ? m_hi : m_lo)) begin
        n_fail++;
        $display("FAIL cyc_hilo t=%0t sel=%b: got %h expected %h", $time, HILOOP, HILO_out,
                 (HILOOP ? m_hi : m_lo));
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic rd(input string nm, input logic [31:0] ehi, input logic [31:0] elo);
    HILOOP = 1'b1; #1;
    chk({nm, "_hi"}, HILO_out, ehi);
    HILOOP = 1'b0; #1;
    chk({nm, "_lo"}, HILO_out, elo);
    chk({nm, "_model_hi"}, m_hi, ehi);
    chk({nm, "_model_lo"}, m_lo, elo);
  endtask

  task automatic wr(input logic hw, input logic lw, input logic [31:0] a);
    @(negedge clk); #1;
    A = a; HIWrite = hw; LOWrite = lw;
    @(negedge clk); #1;
    HIWrite = 1'b0; LOWrite = 1'b0;
  endtask

  // Launch an op, optionally inject a start/HIWrite during the first busy cycle,
  // and count the cycles busy reads high.
  task automatic run_op(input string nm, input logic [1:0] st, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic hw,
                        input logic [1:0] inj_st, input logic inj_hw, input logic [31:0] inj_a,
                        input int exp_n);
    int n;
    n = 0;
    @(negedge clk); #1;
    start = st; multdivOP = op; A = a; B = b; HIWrite = hw;
    @(negedge clk); #1;
    start = inj_st; HIWrite = inj_hw; A = inj_a;
    for (int i = 0; i < 40 && busy; i++) begin
      n++;
      @(negedge clk); #1;
      start = 2'b00; HIWrite = 1'b0;
    end
    start = 2'b00; HIWrite = 1'b0;
    chk({nm, "_busy_cycles"}, 32'(n), 32'(exp_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 0; start = 0; multdivOP = 0; A = 0; B = 0;
    HIWrite = 0; LOWrite = 0; HILOOP = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_lo", HILO_out, 32'h0);
    HILOOP = 1; #1;
    chk("reset_hi", HILO_out, 32'h0);
    HILOOP = 0;
    @(negedge clk); #1;
    reset = 1;
    chk_en = 1;

    run_op("mult_s", 2'b01, 2'b00, 32'hFFFFFFFE, 32'd3, 0, 2'b00, 0, 32'hFFFFFFFE, MULT_CYCLES);
    rd("mult_s", 32'hFFFFFFFF, 32'hFFFFFFFA);

    run_op("multu", 2'b01, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 2'b00, 0, 32'hFFFFFFFF, MULT_CYCLES);
    rd("multu", 32'hFFFFFFFE, 32'h00000001);
    run_op("maddu", 2'b01, 2'b11, 32'd1, 32'd1, 0, 2'b00, 0, 32'd1, MULT_CYCLES);
    rd("maddu", 32'hFFFFFFFE, 32'h00000002);

    run_op("div_s", 2'b10, 2'b00, 32'hFFFFFFF9, 32'd2, 0, 2'b00, 0, 32'hFFFFFFF9, DIV_CYCLES);
    rd("div_s", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 2'b10, 2'b01, 32'hFFFFFFF9, 32'd2, 0, 2'b00, 0, 32'hFFFFFFF9, DIV_CYCLES);
    rd("divu", 32'h00000001, 32'h7FFFFFFC);

    wr(1, 0, 32'h11);
    wr(0, 1, 32'h22);
    rd("mthi_mtlo", 32'h11, 32'h22);
    run_op("div0", 2'b10, 2'b00, 32'd100, 32'd0, 0, 2'b00, 0, 32'd100, DIV_CYCLES);
    rd("div0", 32'h11, 32'h22);

    run_op("div_ovf", 2'b10, 2'b00, 32'h80000000, 32'hFFFFFFFF, 0, 2'b00, 0, 32'h80000000, DIV_CYCLES);
    rd("div_ovf", 32'h0, 32'h80000000);

    // HI visible on the output so a leaked write during RUN shows up cycle by cycle.
    HILOOP = 1;
    run_op("hiw_in_run", 2'b01, 2'b00, 32'd2, 32'd3, 0, 2'b00, 1, 32'h0000ABCD, MULT_CYCLES);
    rd("hiw_in_run", 32'h0, 32'h6);

    HILOOP = 1;
    run_op("start_in_run", 2'b01, 2'b00, 32'd4, 32'd5, 0, 2'b01, 0, 32'd7, MULT_CYCLES);
    rd("start_in_run", 32'h0, 32'h14);

    HILOOP = 1;
    run_op("start_with_hiw", 2'b01, 2'b11, 32'd3, 32'd3, 1, 2'b00, 0, 32'd3, MULT_CYCLES);
    rd("start_with_hiw", 32'h0, 32'h1D);

    HILOOP = 1;
    run_op("noop_with_hiw", 2'b11, 2'b00, 32'h55, 32'd1, 1, 2'b00, 0, 32'h55, 0);
    rd("noop_with_hiw", 32'h0, 32'h1D);

    // Reset on the third busy cycle of a divide.
    @(negedge clk); #1;
    start = 2'b10; multdivOP = 2'b00; A = 32'd100; B = 32'd7;
    @(negedge clk); #1;
    start = 2'b00;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 0;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_lo_now", HILO_out, 32'h0);
    @(negedge clk); #1;
    reset = 1;
    repeat (15) @(negedge clk);
    #1;
    rd("abort", 32'h0, 32'h0);

    run_op("post_abort", 2'b01, 2'b00, 32'd6, 32'd7, 0, 2'b00, 0, 32'd6, MULT_CYCLES);
    rd("post_abort", 32'h0, 32'd42);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Multiply/divide unit for the pipelined MIPS core: the responder side of the `start`/`busy` handshake driven by the control and hazard logic in the execute stage. It captures two 32-bit operands on a start pulse and holds `busy` for a fixed multi-cycle latency. It then commits the result to the HI/LO register pair. It also services `mthi`/`mtlo` writes and `mfhi`/`mflo` reads.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu/madd/maddu; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state immediately.
- `start` in 2: launch code. 00 none, 01 multiply, 10 divide, 11 no-op.
- `multdivOP` in 2: bit0 = 1 selects unsigned, 0 selects signed. Bit1 = 1 on a multiply selects accumulate into HI:LO (madd/maddu); bit1 is ignored on a divide.
- `A` in 32: rs operand (multiplicand / dividend / mthi-mtlo data).
- `B` in 32: rt operand (multiplier / divisor).
- `HIWrite` in 1: mthi, writes A to HI.
- `LOWrite` in 1: mtlo, writes A to LO.
- `HILOOP` in 1: read select; 0 drives LO, 1 drives HI.
- `busy` out 1: operation in flight.
- `HILO_out` out 32: combinational read of HI or LO per `HILOOP`.

## Operation
- States: IDLE and RUN, plus a 4-bit down-counter `cnt` and 64-bit pending-result register `pend`.
- **IDLE, start=01 at an edge:**
  - Compute the 64-bit product: signed when bit0=0, unsigned when bit0=1.
  - If bit1=1, `pend` = {HI,LO} + product, mod 2^64. Otherwise `pend` = product.
  - Set `cnt`=MULT_CYCLES and enter RUN.
- **IDLE, start=10 at an edge:**
  - `pend` = {remainder, quotient}. Signed division truncates toward zero; the remainder takes the dividend's sign. Unsigned division is plain.
  - The special case signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - B == 0: set a `div0` flag. HI/LO stay unchanged at commit, but the busy timing is identical.
  - Set `cnt`=DIV_CYCLES and enter RUN.
- **RUN:** `cnt` decrements each edge. On the edge where `cnt` is 1, commit HI=`pend[63:32]` and LO=`pend[31:0]` unless `div0`, then return to IDLE.
- `busy` = (state == RUN), registered.
- **HIWrite/LOWrite:**
  - In IDLE with start==00, the write takes effect at the edge. Both may be asserted together.
  - In RUN, or coinciding with a start, the write is dropped. The start wins and the operation reads the pre-write HI/LO for accumulate.
- **start != 00 in RUN:** ignored (the hazard unit guarantees this never occurs); `pend`/`cnt` undisturbed.
- `HILO_out` reflects committed HI/LO only; never `pend`.
- **Reset:** HI=0, LO=0, `pend`=0, `cnt`=0, `div0`=0, state IDLE, `busy`=0. Reset mid-RUN aborts with no commit.

## Timing
- Start sampled at edge T0 → `busy`=1 from T0 through the edge T0+N, where N = MULT_CYCLES or DIV_CYCLES. `busy` reads 1 for exactly N cycles.
- The commit and `busy` falling happen at the same edge T0+N. `HILO_out` shows the new value in the cycle after T0+N.
- A new start is accepted at the first edge where `busy` is 0 beforehand, giving back-to-back throughput of one op per N+1 cycles.
- mthi/mtlo latency 1 edge; `HILO_out` is combinational from the registers with 0-cycle read latency.
- The upstream stall condition is start≠00 OR `busy`. This block does not depend on the stall for correctness, beyond dropping commands while in RUN.

## Test plan
- **Signed mult:** reset, then start=01, op=00, A=0xFFFFFFFE (-2), B=3. Expect `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; HILOOP toggles the output.
- **Unsigned mult, then maddu:** multu 0xFFFFFFFF×0xFFFFFFFF gives HI=0xFFFFFFFE, LO=0x00000001. Then maddu A=1, B=1 gives LO=0x00000002, HI=0xFFFFFFFE.
- **Signed div:** div A=-7 (0xFFFFFFF9), B=2. Expect `busy` for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with the same operands gives LO=0x7FFFFFFC, HI=1.
- **Division corner cases:**
  - HI=0x11, LO=0x22 preset via mthi/mtlo, then div by B=0: `busy` for 10 cycles, HI/LO still 0x11/0x22.
  - 0x80000000 / 0xFFFFFFFF signed gives LO=0x80000000, HI=0.
- **Dropped commands:**
  - HIWrite A=0xABCD asserted during RUN is dropped.
  - start=01 during RUN is ignored; the original result commits at its original cycle.
  - start with HIWrite in the same cycle: the operation runs and the HI write is lost.
- **Reset abort:** assert `reset`=0 asynchronously on the 3rd busy cycle of a div. `busy` drops immediately, HI=LO=0, and no commit occurs after release; the next mult completes normally.
